// File: rtl/indicator_pkg.sv
// rtl/indicator_pkg.sv - shared state encoding and cycle-count helpers for indicator blocks
package indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Returns 0 when the rate is zero or faster than the clock, so callers can reject it.
  function automatic int unsigned cycles_from_hz(input int unsigned freq_hz,
                                                 input int unsigned rate_hz);
    if (rate_hz == 0) return 0;
    return freq_hz / rate_hz;
  endfunction

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - loadable down-counter raising a 1-cycle expire flag at zero
module interval_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_abort,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_abort) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_value;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  // A load of N expires on the (N+1)-th cycle after the load edge.
  assign o_expire = r_active && (r_count == '0);

endmodule

// File: rtl/event_blink_indicator.sv
// rtl/event_blink_indicator.sv - turns event pulses into queued, human-visible blinks
// Optional blink_count output enabled by INDICATOR_BLINK_COUNT_EN.
module event_blink_indicator
  import indicator_pkg::*;
#(
  parameter  int unsigned CLK_FREQUENCY = 40_000_000,
  parameter  int unsigned ON_HZ         = 4,
  parameter  int unsigned OFF_HZ        = 4,
  parameter  int unsigned MAX_PENDING   = 7,
  localparam int unsigned PEND_W        = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              event_pulse,
  input  logic              clear,
  output logic              indicator,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef INDICATOR_BLINK_COUNT_EN
  ,output logic [15:0]      blink_count
`endif
);

  localparam int unsigned ON_CYCLES  = cycles_from_hz(CLK_FREQUENCY, ON_HZ);
  localparam int unsigned OFF_CYCLES = cycles_from_hz(CLK_FREQUENCY, OFF_HZ);
  localparam int unsigned TMR_W      = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_cycles
    $error("event_blink_indicator: ON_CYCLES and OFF_CYCLES must both be >= 1");
  end

  state_t            r_state;
  logic              r_indicator;
  logic              r_busy;
  logic              r_overflow;
  logic [PEND_W-1:0] r_pending;

  logic              w_work;
  logic              w_start;
  logic              w_expire;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_value;
  logic [PEND_W-1:0] w_pending_nxt;
  logic              w_overflow_set;

  always_comb begin
    w_work         = (r_pending != '0) || event_pulse;
    w_start        = w_work && ((r_state == IDLE) || (r_state == OFF && w_expire));
    w_tmr_load     = !clear && (w_start || (r_state == ON && w_expire));
    w_tmr_value    = w_start ? ON_LOAD : OFF_LOAD;
    w_pending_nxt  = r_pending;
    w_overflow_set = 1'b0;
    // A start consumes one queued unit; an event arriving with it replaces that unit.
    if (w_start) begin
      if (r_pending != '0 && !event_pulse) begin
        w_pending_nxt = r_pending - PEND_W'(1);
      end
    end else if (event_pulse && r_state != IDLE) begin
      if (r_pending >= PEND_MAX) begin
        w_overflow_set = 1'b1;
      end else begin
        w_pending_nxt = r_pending + PEND_W'(1);
      end
    end
  end

  interval_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_abort  (clear),
    .i_load   (w_tmr_load),
    .i_value  (w_tmr_value),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_indicator <= 1'b0;
      r_busy      <= 1'b0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_indicator <= 1'b0;
      r_busy      <= 1'b0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_overflow_set) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= ON;
            r_indicator <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ON: begin
          if (w_expire) begin
            r_state     <= OFF;
            r_indicator <= 1'b0;
          end
        end
        OFF: begin
          if (w_start) begin
            r_state     <= ON;
            r_indicator <= 1'b1;
          end else if (w_expire) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_indicator <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef INDICATOR_BLINK_COUNT_EN
  logic [15:0] r_blink_count;

  // Counted at ON->OFF so a blink cut short by clear never registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blink_count <= 16'd0;
    end else if (!clear && r_state == ON && w_expire) begin
      r_blink_count <= r_blink_count + 16'd1;
    end
  end

  assign blink_count = r_blink_count;
`endif

  assign indicator = r_indicator;
  assign busy      = r_busy;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_event_blink_indicator.sv
// tb/tb_event_blink_indicator.sv - directed and randomized checks of event_blink_indicator
module tb_event_blink_indicator;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int MAXP  = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       event_pulse;
  logic       clear;
  logic       indicator;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
`ifdef INDICATOR_BLINK_COUNT_EN
  logic [15:0] blink_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: a blink is a window of ON_C high + OFF_C low cycles starting at m_s.
  bit          m_active;
  int          m_s;
  int          m_c;
  int          m_pend;
  bit          m_ovf;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  event_blink_indicator #(
    .CLK_FREQUENCY (8),
    .ON_HZ         (2),
    .OFF_HZ        (4),
    .MAX_PENDING   (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .event_pulse (event_pulse),
    .clear       (clear),
    .indicator   (indicator),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
`ifdef INDICATOR_BLINK_COUNT_EN
    ,.blink_count (blink_count)
`endif
  );

  task automatic model_update(input logic ev, input logic clr, input logic rn);
    int c;
    bit free;
    bit work;
    c = m_c;
    if (!rn) begin
      m_active = 0; m_pend = 0; m_ovf = 0; m_cnt = 16'd0;
    end else begin
      if (m_active && !clr && c == m_s + ON_C - 1) m_cnt = m_cnt + 16'd1;
      if (clr) begin
        m_active = 0; m_pend = 0; m_ovf = 0;
      end else begin
        free = !m_active || (c == m_s + ON_C + OFF_C - 1);
        work = (m_pend > 0) || ev;
        if (free && work) begin
          m_pend   = m_pend - ((m_pend > 0) ? 1 : 0) + ((ev && m_pend > 0) ? 1 : 0);
          m_active = 1;
          m_s      = c + 1;
        end else if (free) begin
          m_active = 0;
        end else if (ev) begin
          if (m_pend == MAXP) m_ovf = 1;
          else m_pend++;
        end
      end
    end
    m_c = c + 1;
  endtask

  function automatic logic [4:0] model_out();
    logic ind;
    logic [1:0] p;
    ind = m_active && ((m_c - m_s) < ON_C);
    p   = m_pend[1:0];
    return {ind, logic'(m_active), p, logic'(m_ovf)};
  endfunction

  task automatic step(input logic ev, input logic clr, input logic rn);
    event_pulse = ev;
    clear       = clr;
    reset_n     = rn;
    model_update(ev, clr, rn);
    @(negedge clk);
    event_pulse = 1'b0;
    clear       = 1'b0;
    reset_n     = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    total++;
    if ({indicator, busy, pending, overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {indicator, busy, pending, overflow}, 5'b0);
    end
`ifdef INDICATOR_BLINK_COUNT_EN
    total++;
    if (blink_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_blink_count got=%0d want=0", blink_count);
    end
`endif
  endtask

  task automatic test_single();
    logic [4:0] exp_v;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      int c;
      step(k == 0, 1'b0, 1'b1);
      c = k + 1;
      exp_v = {logic'(c <= 4), logic'(c <= 6), 2'd0, 1'b0};
      total++;
      if ({indicator, busy, pending, overflow} !== exp_v) begin
        bad++;
        $display("FAIL single c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, exp_v);
      end
      total++;
      if ({indicator, busy, pending, overflow} !== model_out()) begin
        bad++;
        $display("FAIL single_model c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, model_out());
      end
    end
  endtask

  task automatic test_burst();
    logic [4:0] exp_v;
    logic [1:0] ep;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      int c;
      step(k < 3, 1'b0, 1'b1);
      c = k + 1;
      ep = (c < 2) ? 2'd0 : (c == 2) ? 2'd1 : (c <= 6) ? 2'd2 : (c <= 12) ? 2'd1 : 2'd0;
      exp_v = {logic'((c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)),
               logic'(c <= 18), ep, 1'b0};
      total++;
      if ({indicator, busy, pending, overflow} !== exp_v) begin
        bad++;
        $display("FAIL burst c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, exp_v);
      end
      total++;
      if ({indicator, busy, pending, overflow} !== model_out()) begin
        bad++;
        $display("FAIL burst_model c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, model_out());
      end
    end
  endtask

  task automatic test_overflow();
    int   rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    do_reset();
    for (int k = 0; k < 35; k++) begin
      step(k < 5, 1'b0, 1'b1);
      if (indicator && !prev) rises++;
      prev = indicator;
      if (k + 1 == 5) begin
        total++;
        if (pending !== 2'd3 || overflow !== 1'b1) begin
          bad++;
          $display("FAIL overflow_sat got pend=%0d ovf=%b want pend=3 ovf=1", pending, overflow);
        end
      end
      total++;
      if ({indicator, busy, pending, overflow} !== model_out()) begin
        bad++;
        $display("FAIL overflow_model c=%0d got=%b want=%b", k + 1, {indicator, busy, pending, overflow}, model_out());
      end
    end
    total++;
    if (rises !== 4) begin
      bad++;
      $display("FAIL overflow_blinks got=%0d want=4", rises);
    end
    total++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overflow_sticky got ovf=%b busy=%b want ovf=1 busy=0", overflow, busy);
    end
`ifdef INDICATOR_BLINK_COUNT_EN
    total++;
    if (blink_count !== 16'd4) begin
      bad++;
      $display("FAIL overflow_blink_count got=%0d want=4", blink_count);
    end
`endif
  endtask

  task automatic test_coincident();
    logic [4:0] exp_v;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      int c;
      step(k == 0 || k == 6, 1'b0, 1'b1);
      c = k + 1;
      exp_v = {logic'((c <= 4) || (c >= 7 && c <= 10)), logic'(c <= 12), 2'd0, 1'b0};
      total++;
      if ({indicator, busy, pending, overflow} !== exp_v) begin
        bad++;
        $display("FAIL coincident c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, exp_v);
      end
    end
  endtask

  task automatic test_clear();
    logic [4:0] exp_v;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      int c;
      step(k <= 3, k == 3, 1'b1);
      c = k + 1;
      exp_v = (c <= 3) ? {1'b1, 1'b1, 2'(c - 1), 1'b0} : 5'b0;
      total++;
      if ({indicator, busy, pending, overflow} !== exp_v) begin
        bad++;
        $display("FAIL clear c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, exp_v);
      end
      total++;
      if ({indicator, busy, pending, overflow} !== model_out()) begin
        bad++;
        $display("FAIL clear_model c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, model_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_v;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      int c;
      step(k == 0, 1'b0, k != 2);
      c = k + 1;
      exp_v = (c <= 2) ? 5'b11000 : 5'b0;
      total++;
      if ({indicator, busy, pending, overflow} !== exp_v) begin
        bad++;
        $display("FAIL reset_mid c=%0d got=%b want=%b", c, {indicator, busy, pending, overflow}, exp_v);
      end
    end
`ifdef INDICATOR_BLINK_COUNT_EN
    total++;
    if (blink_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_blink_count got=%0d want=0", blink_count);
    end
`endif
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic ev, clr, rn;
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(2, 8);
      ev  = (burst > 0) ? 1'b1 : ($urandom_range(0, 99) < 12);
      if (burst > 0) burst--;
      clr = ($urandom_range(0, 199) == 0);
      rn  = ($urandom_range(0, 599) != 0);
      step(ev, clr, rn);
      total++;
      if ({indicator, busy, pending, overflow} !== model_out()) begin
        bad++;
        $display("FAIL random k=%0d got=%b want=%b", k, {indicator, busy, pending, overflow}, model_out());
      end
`ifdef INDICATOR_BLINK_COUNT_EN
      total++;
      if (blink_count !== m_cnt) begin
        bad++;
        $display("FAIL random_blink_count k=%0d got=%0d want=%0d", k, blink_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    event_pulse = 1'b0;
    clear       = 1'b0;
    m_active    = 0;
    m_s         = 0;
    m_c         = 0;
    m_pend      = 0;
    m_ovf       = 0;
    m_cnt       = 16'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_coincident();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
